// File: rtl/uart_rx_fifo_if.sv
// Bus bundle for uart_rx_fifo: UART receiver strobe/byte plus the MMIO window.
interface uart_rx_fifo_if;
   logic        rxnew;
   logic [7:0]  rxdata;
   logic [2:0]  a;
   logic [31:0] d;
   logic        we;
   logic [31:0] spo;
   logic        irq;

   modport master (output rxnew, rxdata, a, d, we, input spo, irq);
   modport slave  (input rxnew, rxdata, a, d, we, output spo, irq);
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver, with an MMIO window and level irq.
// Optional irq threshold register at 0x04 enabled by UART_RX_FIFO_IRQ_THRESH_EN.
module uart_rx_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_rx_fifo_if.slave  bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr, rptr;
   logic [CW-1:0]         count, count_next, thr;
   logic                  ovf;
   logic                  empty, full, pop_req, push_ok, pop_ok, ovf_set, ovf_clr;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_req = bus.we && (bus.a == 3'd1);
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign push_ok = bus.rxnew && (!full || pop_req);
   assign pop_ok  = pop_req && !empty;
   assign ovf_set = bus.rxnew && full && !pop_req;
   assign ovf_clr = bus.we && (bus.a == 3'd3);
   assign count_next = count + CW'(push_ok) - CW'(pop_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
         bus.irq <= 1'b0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop_ok)  rptr <= rptr + 1'b1;
         count <= count_next;
         if (ovf_set)      ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
         bus.irq <= (count_next >= thr);
      end
   end

   // Storage is deliberately unreset; the empty flag masks stale contents.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= bus.rxdata;
   end

`ifdef UART_RX_FIFO_IRQ_THRESH_EN
   logic [CW-1:0] thr_wr;
   assign thr_wr = bus.d[24+DEPTH_LOG2:24];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         thr <= CW'(1);
      else if (bus.we && (bus.a == 3'd4))
         thr <= (thr_wr == '0)          ? CW'(1)     :
                (thr_wr > CW'(DEPTH))   ? CW'(DEPTH) : thr_wr;
   end
`else
   assign thr = CW'(1);
`endif

   always_comb begin
      bus.spo = 32'b0;
      case (bus.a)
         3'd0: bus.spo = {(empty ? 8'h00 : mem[rptr]), 24'b0};
         3'd1: bus.spo = {7'b0, !empty, 24'b0};
         3'd2: bus.spo = {8'(count), 24'b0};
         3'd3: bus.spo = {7'b0, ovf, 24'b0};
`ifdef UART_RX_FIFO_IRQ_THRESH_EN
         3'd4: bus.spo = {8'(thr), 24'b0};
`endif
         default: bus.spo = 32'b0;
      endcase
   end
endmodule
